// File: rtl/psum_bank_sched.sv
// Row/block/frame sequencer for the PEB with RAM2/RAM3 psum ping-pong ownership.
// A finished frame's bank goes to pooling and is reclaimed only after release.
module psum_bank_sched #(
    parameter int ROW_WIDTH = 6,
    parameter int BLK_WIDTH = 8,
    parameter int FRM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 TOPCTR_Sta,
    input  logic [ROW_WIDTH-1:0] CFG_NumRow,
    input  logic [BLK_WIDTH-1:0] CFG_NumBlk,
    input  logic [FRM_WIDTH-1:0] CFG_NumFrm,
    input  logic                 PECCTR_DonRow,
    input  logic                 POOLCTR_FnhBnk,
    output logic                 PEBPEC_StaRow,
    output logic                 PEBPEC_FnhRow,
    output logic                 PEBPEC_FnhBlk,
    output logic                 PEBPEC_FnhFrm,
    output logic                 CTRPEB_FrtBlk,
    output logic                 CTRPEB_FlgRAM2,
    output logic                 CTRPOOL_RdyBnk,
    output logic                 CTRTOP_Busy,
    output logic                 CTRTOP_Don
);

    typedef enum logic [2:0] {
        IDLE,
        STA,
        RUN,
        ENDROW,
        WAITPOOL,
        DRAIN
    } state_t;

    state_t r_state;
    state_t w_nxt;

    logic [ROW_WIDTH-1:0] r_max_row, r_cnt_row, w_cnt_row, w_cfg_row;
    logic [BLK_WIDTH-1:0] r_max_blk, r_cnt_blk, w_cnt_blk, w_cfg_blk;
    logic [FRM_WIDTH-1:0] r_max_frm, r_cnt_frm, w_cnt_frm, w_cfg_frm;

    logic r_pool_busy;
    logic w_pool_busy;
    logic w_swap;
    logic w_rel;
    logic w_row_last;
    logic w_blk_last;
    logic w_frm_last;
    logic w_don_row;

    // Stored limits are max index, so a zero count collapses to a single pass.
    assign w_cfg_row = (CFG_NumRow == '0) ? '0 : CFG_NumRow - ROW_WIDTH'(1);
    assign w_cfg_blk = (CFG_NumBlk == '0) ? '0 : CFG_NumBlk - BLK_WIDTH'(1);
    assign w_cfg_frm = (CFG_NumFrm == '0) ? '0 : CFG_NumFrm - FRM_WIDTH'(1);

    assign w_row_last = (r_cnt_row == r_max_row);
    assign w_blk_last = (r_cnt_blk == r_max_blk);
    assign w_frm_last = (r_cnt_frm == r_max_frm);
    assign w_rel      = POOLCTR_FnhBnk & r_pool_busy;
    assign w_don_row  = (r_state == RUN) & PECCTR_DonRow;

    always_comb begin
        w_nxt     = r_state;
        w_cnt_row = r_cnt_row;
        w_cnt_blk = r_cnt_blk;
        w_cnt_frm = r_cnt_frm;
        w_swap    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (TOPCTR_Sta) begin
                    w_nxt     = STA;
                    w_cnt_row = '0;
                    w_cnt_blk = '0;
                    w_cnt_frm = '0;
                end
            end
            STA: begin
                // A post-swap entry spends one silent cycle before the pulse.
                if (PEBPEC_StaRow) begin
                    w_nxt = RUN;
                end
            end
            RUN: begin
                if (PECCTR_DonRow) begin
                    w_nxt = ENDROW;
                end
            end
            ENDROW: begin
                if (!(w_row_last && w_blk_last)) begin
                    w_nxt = STA;
                    if (w_row_last) begin
                        w_cnt_row = '0;
                        w_cnt_blk = r_cnt_blk + BLK_WIDTH'(1);
                    end else begin
                        w_cnt_row = r_cnt_row + ROW_WIDTH'(1);
                    end
                end else if (!r_pool_busy || POOLCTR_FnhBnk) begin
                    w_swap = 1'b1;
                end else begin
                    w_nxt = WAITPOOL;
                end
            end
            WAITPOOL: begin
                if (w_rel) begin
                    w_swap = 1'b1;
                end
            end
            DRAIN: begin
                if (w_rel) begin
                    w_nxt = IDLE;
                end
            end
            default: begin
                w_nxt = IDLE;
            end
        endcase
        if (w_swap) begin
            w_cnt_row = '0;
            w_cnt_blk = '0;
            w_cnt_frm = w_frm_last ? '0 : r_cnt_frm + FRM_WIDTH'(1);
            w_nxt     = w_frm_last ? DRAIN : STA;
        end
    end

    always_comb begin
        w_pool_busy = r_pool_busy;
        if (w_swap) begin
            w_pool_busy = 1'b1;
        end else if (w_rel) begin
            w_pool_busy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_max_row      <= '0;
            r_max_blk      <= '0;
            r_max_frm      <= '0;
            r_cnt_row      <= '0;
            r_cnt_blk      <= '0;
            r_cnt_frm      <= '0;
            r_pool_busy    <= 1'b0;
            PEBPEC_StaRow  <= 1'b0;
            PEBPEC_FnhRow  <= 1'b0;
            PEBPEC_FnhBlk  <= 1'b0;
            PEBPEC_FnhFrm  <= 1'b0;
            CTRPEB_FrtBlk  <= 1'b0;
            CTRPEB_FlgRAM2 <= 1'b1;
            CTRTOP_Busy    <= 1'b0;
            CTRTOP_Don     <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_cnt_row   <= w_cnt_row;
            r_cnt_blk   <= w_cnt_blk;
            r_cnt_frm   <= w_cnt_frm;
            r_pool_busy <= w_pool_busy;
            if (r_state == IDLE && TOPCTR_Sta) begin
                r_max_row <= w_cfg_row;
                r_max_blk <= w_cfg_blk;
                r_max_frm <= w_cfg_frm;
            end
            PEBPEC_StaRow  <= (w_nxt == STA) && !w_swap;
            PEBPEC_FnhRow  <= w_don_row;
            PEBPEC_FnhBlk  <= w_don_row && w_row_last;
            PEBPEC_FnhFrm  <= w_don_row && w_row_last && w_blk_last;
            CTRPEB_FrtBlk  <= (w_cnt_blk == '0) && (w_nxt != IDLE) && (w_nxt != DRAIN);
            CTRPEB_FlgRAM2 <= CTRPEB_FlgRAM2 ^ w_swap;
            CTRTOP_Busy    <= (w_nxt != IDLE);
            CTRTOP_Don     <= (r_state == DRAIN) && w_rel;
        end
    end

    assign CTRPOOL_RdyBnk = r_pool_busy;

endmodule

// File: tb/tb_psum_bank_sched.sv
// Scoreboard bench for psum_bank_sched: stimulus queues expected output events,
// a negedge monitor pops and compares them with cycle stamps.
module tb_psum_bank_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sta = 1'b0;
    logic [5:0] nrow = '0;
    logic [7:0] nblk = '0;
    logic [7:0] nfrm = '0;
    logic       donrow = 1'b0;
    logic       fnhbnk = 1'b0;

    logic starow, fnhrow, fnhblk, fnhfrm, frtblk, flg, rdy, busy, don;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int s;
    int d;
    int w;

    logic m_flg = 1'b1;
    logic m_rdy = 1'b0;

    typedef struct {
        int         c;
        logic [8:0] v;
    } exp_t;
    exp_t q[$];

    psum_bank_sched #(.ROW_WIDTH(6), .BLK_WIDTH(8), .FRM_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .TOPCTR_Sta(sta),
        .CFG_NumRow(nrow),
        .CFG_NumBlk(nblk),
        .CFG_NumFrm(nfrm),
        .PECCTR_DonRow(donrow),
        .POOLCTR_FnhBnk(fnhbnk),
        .PEBPEC_StaRow(starow),
        .PEBPEC_FnhRow(fnhrow),
        .PEBPEC_FnhBlk(fnhblk),
        .PEBPEC_FnhFrm(fnhfrm),
        .CTRPEB_FrtBlk(frtblk),
        .CTRPEB_FlgRAM2(flg),
        .CTRPOOL_RdyBnk(rdy),
        .CTRTOP_Busy(busy),
        .CTRTOP_Don(don)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit order: StaRow FnhRow FnhBlk FnhFrm FrtBlk FlgRAM2 RdyBnk Don Busy
    function automatic logic [8:0] vec(input bit sr, fr, fb, ff, frt, dn, bz);
        return {sr, fr, fb, ff, frt, m_flg, m_rdy, dn, bz};
    endfunction

    task automatic push(input int c, input logic [8:0] v);
        exp_t e;
        e.c = c;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string n, input logic [8:0] a, input logic [8:0] r);
        checks++;
        if (a !== r) begin
            failures++;
            $display("FAIL %s got=%b required=%b", n, a, r);
        end
    endtask

    task automatic start(input int r, input int b, input int f, output int so);
        nrow = 6'(r);
        nblk = 8'(b);
        nfrm = 8'(f);
        sta  = 1'b1;
        push(cyc + 1, vec(1, 0, 0, 0, 1, 0, 1));
        tick();
        sta = 1'b0;
        so  = cyc;
    endtask

    // StaRow seen at cycle st; DonRow raised gap cycles later for one cycle.
    task automatic row(input int st, input int gap, input bit fb, input bit ff, input bit frt);
        goto(st + gap);
        donrow = 1'b1;
        push(st + gap + 1, vec(0, 1, fb, ff, frt, 0, 1));
        tick();
        donrow = 1'b0;
    endtask

    initial begin : monitor
        logic [8:0] o;
        logic       pf;
        logic       pr;
        exp_t       e;
        pf = 1'b1;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            o = {starow, fnhrow, fnhblk, fnhfrm, frtblk, flg, rdy, don, busy};
            if (!rst && (o[8] || o[7] || o[1] || o[3] != pf || o[2] != pr)) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d got=%b", cyc, o);
                end else begin
                    e = q.pop_front();
                    if (e.c != cyc || e.v !== o) begin
                        failures++;
                        $display("FAIL event cyc=%0d got=%b required cyc=%0d val=%b",
                                 cyc, o, e.c, e.v);
                    end
                end
            end
            pf = o[3];
            pr = o[2];
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : stim
        tick();
        tick();
        chk("reset_outputs", {starow, fnhrow, fnhblk, fnhfrm, frtblk, flg, rdy, don, busy},
            9'b0_0000_1000);
        rst = 1'b0;
        tick();

        // Basic: 3 rows x 2 blocks x 1 frame
        start(3, 2, 1, s);
        for (int r = 0; r < 6; r++) begin
            row(s, 5, (r % 3) == 2, r == 5, r < 3);
            if (r < 5) begin
                s = s + 7;
                push(s, vec(1, 0, 0, 0, (r + 1) < 3, 0, 1));
            end
        end
        m_flg = ~m_flg;
        m_rdy = 1'b1;
        push(s + 7, vec(0, 0, 0, 0, 0, 0, 1));
        goto(s + 9);
        fnhbnk = 1'b1;
        m_rdy  = 1'b0;
        push(s + 10, vec(0, 0, 0, 0, 0, 1, 0));
        tick();
        fnhbnk = 1'b0;
        goto(s + 13);

        // Abort during block 1
        start(2, 2, 1, s);
        row(s, 2, 0, 0, 1);
        s = s + 4;
        push(s, vec(1, 0, 0, 0, 1, 0, 1));
        row(s, 2, 1, 0, 1);
        s = s + 4;
        push(s, vec(1, 0, 0, 0, 0, 0, 1));
        goto(s + 2);
        rst = 1'b1;
        tick();
        chk("abort_outputs", {starow, fnhrow, fnhblk, fnhfrm, frtblk, flg, rdy, don, busy},
            9'b0_0000_1000);
        tick();
        rst   = 1'b0;
        m_flg = 1'b1;
        m_rdy = 1'b0;
        goto(cyc + 4);

        // Backpressure: 2 single-row frames, pool holds bank
        start(1, 1, 2, s);
        row(s, 2, 1, 1, 1);
        m_flg = ~m_flg;
        m_rdy = 1'b1;
        push(s + 4, vec(0, 0, 0, 0, 1, 0, 1));
        s = s + 5;
        push(s, vec(1, 0, 0, 0, 1, 0, 1));
        row(s, 2, 1, 1, 1);
        goto(s + 5);
        sta = 1'b1;
        tick();
        sta    = 1'b0;
        donrow = 1'b1;
        tick();
        donrow = 1'b0;
        w = s + 8;
        goto(w);
        fnhbnk = 1'b1;
        m_flg  = ~m_flg;
        push(w + 1, vec(0, 0, 0, 0, 0, 0, 1));
        tick();
        fnhbnk = 1'b0;
        d = w + 3;
        goto(d);
        fnhbnk = 1'b1;
        m_rdy  = 1'b0;
        push(d + 1, vec(0, 0, 0, 0, 0, 1, 0));
        tick();
        fnhbnk = 1'b0;
        goto(cyc + 3);

        // Release coincident with frame-end swap
        start(1, 1, 2, s);
        row(s, 2, 1, 1, 1);
        m_flg = ~m_flg;
        m_rdy = 1'b1;
        push(s + 4, vec(0, 0, 0, 0, 1, 0, 1));
        s = s + 5;
        push(s, vec(1, 0, 0, 0, 1, 0, 1));
        row(s, 2, 1, 1, 1);
        fnhbnk = 1'b1;
        m_flg  = ~m_flg;
        push(s + 4, vec(0, 0, 0, 0, 0, 0, 1));
        tick();
        fnhbnk = 1'b0;
        d = s + 6;
        goto(d);
        fnhbnk = 1'b1;
        m_rdy  = 1'b0;
        push(d + 1, vec(0, 0, 0, 0, 0, 1, 0));
        tick();
        fnhbnk = 1'b0;
        goto(cyc + 3);

        // Zero config, DonRow held from before RUN
        d      = cyc;
        nrow   = '0;
        nblk   = '0;
        nfrm   = '0;
        sta    = 1'b1;
        donrow = 1'b1;
        push(d + 1, vec(1, 0, 0, 0, 1, 0, 1));
        push(d + 3, vec(0, 1, 1, 1, 1, 0, 1));
        tick();
        sta = 1'b0;
        goto(d + 3);
        donrow = 1'b0;
        m_flg  = ~m_flg;
        m_rdy  = 1'b1;
        push(d + 4, vec(0, 0, 0, 0, 0, 0, 1));
        goto(d + 6);
        fnhbnk = 1'b1;
        m_rdy  = 1'b0;
        push(d + 7, vec(0, 0, 0, 0, 0, 1, 0));
        tick();
        fnhbnk = 1'b0;
        goto(cyc + 5);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
